bridge_router: RTL and testbench
================================

// Module: bridge_router
// PURPOSE
//  Sits between the APF host bridge and the bridge slaves (bridge_id, config regs, etc.).
//  Decodes addr[31:28] into one of NUM_SLAVES regions and forwards posted writes and reads.
//  Routes the selected slave's rd_data back upstream.
//  Answers unmapped or non-responding reads with UNMAPPED_DATA, so the host never hangs.
// PARAMETERS
//  NUM_SLAVES      4             slave count, 1..16; slave i owns addr[31:28]==i
//  TIMEOUT_CYCLES  64            cycles to wait for s_rd_data_valid before a forced reply, >=2
//  UNMAPPED_DATA   32'hDEAD_BEEF rd_data returned on unmapped or timed-out reads
// PORTS
//  clk              in   1        bridge clock; single clock domain
//  reset_n          in   1        asynchronous, active-low reset
//  addr             in   32       host byte address
//  wr               in   1        host write strobe, 1-cycle pulse
//  wr_data          in   32       host write data
//  rd               in   1        host read strobe, 1-cycle pulse
//  rd_data          out  32       read reply data, held until the next reply
//  rd_data_valid    out  1        1-cycle pulse with rd_data
//  s_addr           out  32       registered addr, shared by all slaves
//  s_wr_data        out  32       registered wr_data, shared by all slaves
//  s_wr             out  NUM_SLAVES   one-hot write strobe
//  s_rd             out  NUM_SLAVES   one-hot read strobe
//  s_rd_data        in   32*NUM_SLAVES  slave i data at [32*i+:32]
//  s_rd_data_valid  in   NUM_SLAVES   per-slave reply pulse
//  err_clear        in   1        clears the sticky error flags
//  err_timeout      out  1        sticky: a read timed out
//  err_overlap      out  1        sticky: a request was dropped
// BEHAVIOUR
//  Reset: all outputs 0; FSM enters IDLE; timeout counter 0. Reset is asynchronous, so a pending read is abandoned with no reply.
//  Request register: on rd or wr at cycle T, latch addr and wr_data into s_addr and s_wr_data at T+1.
//   sel = addr[31:28]; the region is mapped when sel < NUM_SLAVES.
//  Writes (posted): s_wr[sel] pulses at T+1, in any FSM state. An unmapped write is silently dropped.
//  FSM states: IDLE and WAIT.
//   IDLE, rd mapped: s_rd[sel] pulses at T+1. Latch sel. Go to WAIT with counter=0.
//   IDLE, rd unmapped: rd_data=UNMAPPED_DATA and rd_data_valid pulse at T+1. Stay in IDLE.
//   WAIT, s_rd_data_valid[sel_q] high: rd_data<=s_rd_data[sel_q], rd_data_valid pulse next cycle, go to IDLE.
//   WAIT, no valid: counter increments. When counter==TIMEOUT_CYCLES-1 with no valid, reply UNMAPPED_DATA next cycle, set err_timeout, go to IDLE.
//   A valid arriving in the same cycle as expiry wins: real data, no error.
//  Latency: a slave that replies 1 cycle after s_rd (e.g. bridge_id) gives upstream rd_data_valid at T+3.
//  Ignored inputs:
//   valid from a non-selected slave, at any time;
//   any valid while in IDLE (a stray or late reply after a timeout).
//  Overlap rules:
//   rd while in WAIT: dropped, err_overlap set, the pending read continues.
//   rd and wr in the same cycle: wr is forwarded, rd is dropped, err_overlap set.
//  rd_data_valid is never high in two consecutive cycles.
//  err_clear clears both flags. An error event in the same cycle as err_clear wins, and the flag stays 1.
// TESTING
//  Reset with reset_n=0: every output is 0. Deassert, then idle 10 cycles: no strobes.
//  wr addr=32'h1000_0008 data=32'hCAFE_0001 at T: s_wr=4'b0010 at T+1, s_addr=32'h1000_0008, s_wr_data=32'hCAFE_0001.
//  rd addr=32'h0000_0004, slave0 model replies 32'h1234_5678 one cycle after s_rd: rd_data=32'h1234_5678 with a 1-cycle valid at T+3.
//  rd addr=32'h7000_0000 (unmapped, NUM_SLAVES=4): rd_data=32'hDEAD_BEEF, valid at T+1, no s_rd pulse, err flags stay 0.
//  rd to slave2 which never replies: at T+1+TIMEOUT_CYCLES, rd_data=32'hDEAD_BEEF with a valid pulse and err_timeout=1.
//   A late slave2 valid is then ignored. err_clear clears the flag.
//  Second rd while in WAIT: err_overlap=1 and exactly one reply. Also drop reset_n while in WAIT: no reply, FSM returns to IDLE, the next rd completes normally.

Source files
------------

// File: rtl/bridge_router_if.sv
// Bus bundle between the host bridge and bridge_router: host request/reply,
// shared slave request bus, per-slave read replies and sticky error flags.
interface bridge_router_if #(
    parameter int NUM_SLAVES = 4
);
    logic [31:0]              addr;
    logic                     wr;
    logic [31:0]              wr_data;
    logic                     rd;
    logic [31:0]              rd_data;
    logic                     rd_data_valid;
    logic [31:0]              s_addr;
    logic [31:0]              s_wr_data;
    logic [NUM_SLAVES-1:0]    s_wr;
    logic [NUM_SLAVES-1:0]    s_rd;
    logic [32*NUM_SLAVES-1:0] s_rd_data;
    logic [NUM_SLAVES-1:0]    s_rd_data_valid;
    logic                     err_clear;
    logic                     err_timeout;
    logic                     err_overlap;

    // Router side
    modport slave (
        input  addr, wr, wr_data, rd,
        input  s_rd_data, s_rd_data_valid, err_clear,
        output rd_data, rd_data_valid,
        output s_addr, s_wr_data, s_wr, s_rd,
        output err_timeout, err_overlap
    );

    // Host / slave-model side
    modport master (
        output addr, wr, wr_data, rd,
        output s_rd_data, s_rd_data_valid, err_clear,
        input  rd_data, rd_data_valid,
        input  s_addr, s_wr_data, s_wr, s_rd,
        input  err_timeout, err_overlap
    );
endinterface

// File: rtl/bridge_router.sv
// Address decoder between the host bridge and NUM_SLAVES bridge slaves.
// Ports: clk, reset_n (async, active-low), bus (bridge_router_if.slave).
module bridge_router #(
    parameter int          NUM_SLAVES     = 4,
    parameter int          TIMEOUT_CYCLES = 64,
    parameter logic [31:0] UNMAPPED_DATA  = 32'hDEAD_BEEF
) (
    input  logic            clk,
    input  logic            reset_n,
    bridge_router_if.slave  bus
);
    localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CW-1:0]         r_cnt;
    logic [SW-1:0]         r_sel_q;
    logic [31:0]           r_s_addr;
    logic [31:0]           r_s_wr_data;
    logic [NUM_SLAVES-1:0] r_s_wr;
    logic [NUM_SLAVES-1:0] r_s_rd;
    logic [31:0]           r_rd_data;
    logic                  r_rd_data_valid;
    logic                  r_pend;
    logic [31:0]           r_pend_data;
    logic                  r_err_timeout;
    logic                  r_err_overlap;

    logic [3:0]            w_sel;
    logic                  w_mapped;
    logic [NUM_SLAVES-1:0] w_onehot;
    logic                  w_slv_valid;
    logic [31:0]           w_slv_data;
    logic                  w_issue_rd;
    logic                  w_rep;
    logic [31:0]           w_rep_data;
    logic                  w_timeout;
    logic                  w_rd_drop;
    logic                  w_overflow;

    assign w_sel    = bus.addr[31:28];
    assign w_mapped = ({1'b0, w_sel} < 5'(NUM_SLAVES));
    assign w_onehot = NUM_SLAVES'(1) << w_sel;

    // Reply mux for the slave owning the pending read
    always_comb begin
        w_slv_valid = 1'b0;
        w_slv_data  = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (r_sel_q == SW'(i)) begin
                w_slv_valid = bus.s_rd_data_valid[i];
                w_slv_data  = bus.s_rd_data[32*i +: 32];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue_rd  = 1'b0;
        w_rep       = 1'b0;
        w_rep_data  = UNMAPPED_DATA;
        w_timeout   = 1'b0;
        // A read coinciding with a write always loses
        w_rd_drop   = bus.rd & bus.wr;
        unique case (r_state)
            S_IDLE: begin
                if (bus.rd && !bus.wr) begin
                    if (w_mapped) begin
                        w_issue_rd  = 1'b1;
                        w_state_nxt = S_WAIT;
                    end else begin
                        w_rep = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (bus.rd) begin
                    w_rd_drop = 1'b1;
                end
                // Real data wins over a simultaneous expiry
                if (w_slv_valid) begin
                    w_rep       = 1'b1;
                    w_rep_data  = w_slv_data;
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_rep       = 1'b1;
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A reply can only be lost when both the output and hold slot are busy
    assign w_overflow = w_rep & r_rd_data_valid & r_pend;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_sel_q <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_WAIT && w_state_nxt == S_WAIT) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
            if (w_issue_rd) begin
                r_sel_q <= SW'(w_sel);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s_addr    <= '0;
            r_s_wr_data <= '0;
            r_s_wr      <= '0;
            r_s_rd      <= '0;
        end else begin
            if (bus.rd || bus.wr) begin
                r_s_addr    <= bus.addr;
                r_s_wr_data <= bus.wr_data;
            end
            r_s_wr <= (bus.wr && w_mapped) ? w_onehot : '0;
            r_s_rd <= w_issue_rd ? w_onehot : '0;
        end
    end

    // Replies that would land right after a valid pulse wait one cycle
    // in a hold slot so rd_data_valid never stays high two cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_data       <= '0;
            r_rd_data_valid <= 1'b0;
            r_pend          <= 1'b0;
            r_pend_data     <= '0;
        end else begin
            r_rd_data_valid <= 1'b0;
            if (!r_rd_data_valid && r_pend) begin
                r_rd_data       <= r_pend_data;
                r_rd_data_valid <= 1'b1;
                r_pend          <= w_rep;
                if (w_rep) begin
                    r_pend_data <= w_rep_data;
                end
            end else if (!r_rd_data_valid && w_rep) begin
                r_rd_data       <= w_rep_data;
                r_rd_data_valid <= 1'b1;
            end else if (w_rep && !r_pend) begin
                r_pend      <= 1'b1;
                r_pend_data <= w_rep_data;
            end
        end
    end

    // Sticky flags; a new event beats a simultaneous clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err_timeout <= 1'b0;
            r_err_overlap <= 1'b0;
        end else begin
            r_err_timeout <= w_timeout |
                             (r_err_timeout & ~bus.err_clear);
            r_err_overlap <= w_rd_drop | w_overflow |
                             (r_err_overlap & ~bus.err_clear);
        end
    end

    assign bus.s_addr        = r_s_addr;
    assign bus.s_wr_data     = r_s_wr_data;
    assign bus.s_wr          = r_s_wr;
    assign bus.s_rd          = r_s_rd;
    assign bus.rd_data       = r_rd_data;
    assign bus.rd_data_valid = r_rd_data_valid;
    assign bus.err_timeout   = r_err_timeout;
    assign bus.err_overlap   = r_err_overlap;
endmodule

// File: tb/tb_bridge_router.sv
// Scoreboard bench for bridge_router: host reads/writes, slave models,
// timeout, overlap and reset-abandon scenarios.
module tb_bridge_router;
    localparam int NS = 4;
    localparam int TO = 16;
    localparam logic [31:0] UNM = 32'hDEAD_BEEF;

    typedef struct {
        logic [31:0] d;
        int          c;
    } exp_t;

    logic     clk = 1'b0;
    logic     reset_n;
    int       cyc = 0;
    int       n_chk = 0;
    int       n_fail = 0;
    exp_t     q[$];
    logic     prev_v = 1'b0;
    logic [NS-1:0] en;
    logic [NS-1:0] inj;
    logic [NS-1:0] r_spend = '0;
    logic [NS-1:0] r_spend_q = '0;
    logic     any_strobe;
    int       n0;

    bridge_router_if #(.NUM_SLAVES(NS)) bus ();

    bridge_router #(
        .NUM_SLAVES    (NS),
        .TIMEOUT_CYCLES(TO),
        .UNMAPPED_DATA (UNM)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign bus.s_rd_data = {32'h3333_0003, 32'h2222_0002,
                            32'h1111_0001, 32'h1234_5678};
    assign bus.s_rd_data_valid = r_spend_q | inj;

    // Slave model: reply one cycle after its s_rd pulse when enabled
    always @(negedge clk) begin
        r_spend_q = r_spend;
        r_spend   = bus.s_rd & en;
    end

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.rd_data_valid) begin
                check("no_b2b_valid", 32'(prev_v), 32'd0);
                if (q.size() == 0) begin
                    check("spurious_reply", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("rd_data", bus.rd_data, e.d);
                    check("rd_cycle", 32'(cyc), 32'(e.c));
                end
            end
            prev_v = bus.rd_data_valid;
        end else begin
            prev_v = 1'b0;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_wr(input logic [31:0] a, input logic [31:0] d,
                         input logic [NS-1:0] exp_swr);
        bus.addr    = a;
        bus.wr_data = d;
        bus.wr      = 1'b1;
        @(negedge clk);
        bus.wr = 1'b0;
        check("s_wr", 32'(bus.s_wr), 32'(exp_swr));
        check("s_addr", bus.s_addr, a);
        check("s_wr_data", bus.s_wr_data, d);
    endtask

    task automatic do_rd(input logic [31:0] a,
                         input logic [NS-1:0] exp_srd,
                         input logic push,
                         input logic [31:0] ed,
                         input int lat);
        bus.addr = a;
        bus.rd   = 1'b1;
        if (push) q.push_back(exp_t'{ed, cyc + lat});
        @(negedge clk);
        bus.rd = 1'b0;
        check("s_rd", 32'(bus.s_rd), 32'(exp_srd));
    endtask

    task automatic pulse_clear();
        bus.err_clear = 1'b1;
        @(negedge clk);
        bus.err_clear = 1'b0;
    endtask

    initial begin
        reset_n       = 1'b0;
        bus.addr      = '0;
        bus.wr        = 1'b0;
        bus.wr_data   = '0;
        bus.rd        = 1'b0;
        bus.err_clear = 1'b0;
        en            = '1;
        inj           = '0;
        idle(3);
        check("rst_rd_data", bus.rd_data, 32'd0);
        check("rst_valid", 32'(bus.rd_data_valid), 32'd0);
        check("rst_s_addr", bus.s_addr, 32'd0);
        check("rst_s_wr_data", bus.s_wr_data, 32'd0);
        check("rst_strobes", 32'({bus.s_wr, bus.s_rd}), 32'd0);
        check("rst_errs",
              32'({bus.err_timeout, bus.err_overlap}), 32'd0);
        reset_n    = 1'b1;
        any_strobe = 1'b0;
        repeat (10) begin
            @(negedge clk);
            any_strobe = any_strobe | (|bus.s_wr) | (|bus.s_rd) |
                         bus.rd_data_valid;
        end
        check("idle_strobes", 32'(any_strobe), 32'd0);

        do_wr(32'h1000_0008, 32'hCAFE_0001, 4'b0010);
        do_wr(32'h3000_0000, 32'h0000_00A5, 4'b1000);
        do_wr(32'h7000_0000, 32'h0000_0077, 4'b0000);
        idle(2);

        do_rd(32'h0000_0004, 4'b0001, 1'b1, 32'h1234_5678, 3);
        idle(4);
        do_rd(32'h7000_0000, 4'b0000, 1'b1, UNM, 1);
        idle(2);
        check("unmapped_errs",
              32'({bus.err_timeout, bus.err_overlap}), 32'd0);
        do_rd(32'h1000_0040, 4'b0010, 1'b1, 32'h1111_0001, 3);
        idle(4);

        en[2] = 1'b0;
        do_rd(32'h2000_0000, 4'b0100, 1'b1, UNM, 1 + TO);
        idle(TO + 1);
        check("err_timeout_set", 32'(bus.err_timeout), 32'd1);
        check("timeout_reply", 32'(q.size()), 32'd0);
        inj[2] = 1'b1;
        @(negedge clk);
        inj[2] = 1'b0;
        idle(3);
        pulse_clear();
        check("err_timeout_clr", 32'(bus.err_timeout), 32'd0);

        n0 = cyc;
        do_rd(32'h2000_0000, 4'b0100, 1'b1, 32'h2222_0002, 1 + TO);
        idle(n0 + TO - cyc);
        inj[2] = 1'b1;
        @(negedge clk);
        inj[2] = 1'b0;
        idle(3);
        check("expiry_race_err", 32'(bus.err_timeout), 32'd0);
        check("expiry_race_reply", 32'(q.size()), 32'd0);

        do_rd(32'h1000_0010, 4'b0010, 1'b1, 32'h1111_0001, 3);
        do_rd(32'h0000_0000, 4'b0000, 1'b0, 32'd0, 0);
        idle(4);
        check("err_overlap_wait", 32'(bus.err_overlap), 32'd1);
        check("overlap_one_reply", 32'(q.size()), 32'd0);
        pulse_clear();
        check("err_overlap_clr", 32'(bus.err_overlap), 32'd0);

        bus.addr    = 32'h1000_0020;
        bus.wr_data = 32'h0000_0055;
        bus.wr      = 1'b1;
        bus.rd      = 1'b1;
        @(negedge clk);
        bus.wr = 1'b0;
        bus.rd = 1'b0;
        check("rdwr_s_wr", 32'(bus.s_wr), 32'b0010);
        check("rdwr_s_rd", 32'(bus.s_rd), 32'd0);
        check("rdwr_overlap", 32'(bus.err_overlap), 32'd1);
        idle(3);
        bus.err_clear = 1'b1;
        bus.addr      = 32'h0000_0000;
        bus.wr        = 1'b1;
        bus.rd        = 1'b1;
        @(negedge clk);
        bus.err_clear = 1'b0;
        bus.wr        = 1'b0;
        bus.rd        = 1'b0;
        check("clear_vs_event", 32'(bus.err_overlap), 32'd1);
        pulse_clear();

        do_rd(32'h0000_0000, 4'b0001, 1'b1, 32'h1234_5678, 3);
        idle(2);
        do_rd(32'h5000_0000, 4'b0000, 1'b1, UNM, 2);
        idle(4);

        en[3] = 1'b0;
        do_rd(32'h3000_0000, 4'b1000, 1'b0, 32'd0, 0);
        idle(3);
        reset_n = 1'b0;
        @(negedge clk);
        check("wait_rst_valid", 32'(bus.rd_data_valid), 32'd0);
        check("wait_rst_s_rd", 32'(bus.s_rd), 32'd0);
        reset_n = 1'b1;
        idle(TO + 2);
        do_rd(32'h0000_0100, 4'b0001, 1'b1, 32'h1234_5678, 3);
        idle(4);
        check("post_rst_errs",
              32'({bus.err_timeout, bus.err_overlap}), 32'd0);
        check("sb_empty", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
